aes_128_decrypt: RTL
====================

# aes_128_decrypt

Iterative AES-128 inverse cipher. It is the decrypt-side counterpart of the existing AES-128 encrypt top. It accepts a 128-bit ciphertext and cipher key under a valid/ready handshake and expands the key forward to round key 10. It then runs the FIPS-197 inverse cipher one round per cycle, deriving earlier round keys on the fly with the inverse key schedule. It sits beside the encrypt top in the crypto datapath and returns registered plaintext with a one-cycle `valid_out` pulse.

## Interface
- `DATA_W`, default 128: data width; only 128 is supported.
- `KEY_L`, default 128: key length; only 128 is supported.

- `clk`  input  1  system clock; the block uses one clock, all logic on the rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `valid_in`  input  1  request; sampled only when `ready_out`=1.
- `ready_out`  output  1  block idle; equals (state==IDLE); value 1 during and after reset.
- `cipher_key`  input  KEY_L  cipher key; captured on accept.
- `cipher_text`  input  DATA_W  ciphertext; captured on accept.
- `plain_text`  output  DATA_W  registered plaintext; reset 0; holds its value until the next completion.
- `valid_out`  output  1  one-cycle pulse when `plain_text` updates; reset 0.

## Operation
- FSM states: IDLE, KEYEXP, DEC.
- IDLE:
  - Accept when `valid_in`=1.
  - Capture `cipher_text` into the state register and `cipher_key` into the round-key register `rk`.
  - Set `rnd`=1 and go to KEYEXP.
- KEYEXP (`rnd` 1..10):
  - `rk` <= fwd_step(`rk`, rcon[`rnd`]).
  - At `rnd`=10 also load state <= state ^ fwd_step(...), i.e. ciphertext ^ rk10.
  - Then set `rnd`=9 and go to DEC.
- DEC (`rnd` 9..0), each cycle:
  - prev = inv_step(`rk`, rcon[`rnd`+1]), where inv_step recovers round key `rnd` from round key `rnd`+1.
  - t = InvSubBytes(InvShiftRows(state)) ^ prev.
  - For `rnd`≥1: state <= InvMixColumns(t); `rk` <= prev; decrement `rnd`.
  - For `rnd`=0: `plain_text` <= t; `valid_out` <= 1; go to IDLE.
- All byte arithmetic is in GF(2^8) with polynomial 0x11B.
- Byte 0 is bits [127:120]. The state is column-major, per FIPS-197.
- `valid_in` is ignored while busy. There is no queuing, and the caller must hold the request until it is accepted.
- Reset mid-operation aborts the request immediately: FSM to IDLE, `rnd`, state, `rk` and the key cache all cleared. No `valid_out` is issued for the aborted request.

## Timing
- Accept edge E0 (`valid_in`=1 and `ready_out`=1).
- KEYEXP spans edges E1..E10; DEC spans edges E11..E20.
- `valid_out`=1 and `plain_text` valid in the cycle after E20, so latency is 21 cycles.
- `ready_out` returns to 1 in that same cycle. A new request can therefore be accepted on E21, giving a throughput of one block per 21 cycles.
- `valid_out` lasts exactly one cycle.

## Configuration
- `AES_DEC_KEY_CACHE_EN` defined:
  - Add a cached key, cached rk10 and a cache-valid flag. The flag is 0 on reset.
  - On a KEYEXP completion, store the key and rk10 and set the flag.
  - On accept, if the flag is set and `cipher_key` equals the cached key: load `rk`=rk10 and state=ciphertext^rk10, and go straight to DEC.
  - On a hit, latency is 11 cycles (DEC on E1..E10, `valid_out` after E10).
  - On a miss, behaviour is as without the macro.
- `AES_DEC_KEY_CACHE_EN` undefined: KEYEXP always runs and latency is always 21.

## Structure
- Package `aes_pkg` holds:
  - S-box and inverse S-box constants.
  - rcon[1..10].
  - FSM state enum.
  - Functions `fwd_step` and `inv_step` for the key schedule.
  - GF(2^8) xtime / multiply functions.
- Sub-module `aes_inv_round` is combinational and produces t and the InvMixColumns output.
- The top contains the FSM, counter, registers and optional cache.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: pt 00112233445566778899aabbccddeeff, `valid_out` exactly 21 cycles after accept, width 1.
  - Probe: `rk` after KEYEXP = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Required: pt 3243f6a8885a308d313198a2e0370734.
- Busy and back-to-back:
  - Hold `valid_in`=1 continuously with changing data: only requests sampled with `ready_out`=1 are accepted, at one per 21 cycles, each with correct pt.
- Reset mid-run:
  - Assert `reset_n`=0 at cycle 8 of a decrypt: `valid_out`=0, `plain_text`=0, `ready_out`=1.
  - The next C.1 request completes correctly in 21 cycles.
- Key cache (with `AES_DEC_KEY_CACHE_EN`):
  - Run C.1, then repeat the same key with ct 69c4...: latency 11, pt 0011...eeff.
  - Then the B key: latency 21.
  - Then a reset followed by the C.1 key: latency 21.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES-128 inverse cipher: S-boxes, round
// constants, FSM state type, key-schedule steps and GF(2^8) arithmetic.
package aes_pkg;

  localparam int NCOL = 4;

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_e;

  // Index 0 is the leftmost byte of each table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant of at most 4 bits (enough for InvMixColumns).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {INV_SBOX[w[31:24]], INV_SBOX[w[23:16]], INV_SBOX[w[15:8]], INV_SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    {w0, w1, w2, w3} = rk;
    n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo fwd_step: the last three words fall out by xor, the first needs w3.
  function automatic logic [127:0] inv_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
    {n0, n1, n2, n3} = rk;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_col.sv
// One state column of an inverse round: InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_col
  import aes_pkg::*;
(
  input  logic [31:0] sr_i,
  input  logic [31:0] rk_i,
  output logic [31:0] t_o,
  output logic [31:0] mix_o
);
  assign t_o   = inv_sub_word(sr_i) ^ rk_i;
  assign mix_o = inv_mix_col(t_o);
endmodule

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows routing feeding four column slices.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  output logic [127:0] t_o,
  output logic [127:0] mix_o
);
  logic [NCOL-1:0][31:0] col_sr, col_rk, col_t, col_mix;

  // Byte (r,c) sits at index 4c+r; InvShiftRows pulls row r from column c-r.
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign col_sr[c][8*(3-r) +: 8] = state_i[8*(15-(4*((c+4-r)%4)+r)) +: 8];
    end
    assign col_rk[c]              = rk_i[32*(3-c) +: 32];
    assign t_o[32*(3-c) +: 32]   = col_t[c];
    assign mix_o[32*(3-c) +: 32] = col_mix[c];
  end

  aes_inv_col u_col [NCOL-1:0] (
    .sr_i  (col_sr),
    .rk_i  (col_rk),
    .t_o   (col_t),
    .mix_o (col_mix)
  );
endmodule

// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 decrypt: forward key expansion to rk10, then one inverse round
// per cycle with on-the-fly inverse key schedule. AES_DEC_KEY_CACHE_EN adds an rk10 cache.
module aes_128_decrypt
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int KEY_L  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [KEY_L-1:0]  cipher_key,
  input  logic [DATA_W-1:0] cipher_text,
  output logic [DATA_W-1:0] plain_text,
  output logic              valid_out
);
  state_e       fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d, rk_q, rk_d, pt_q, pt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         vout_q, vout_d;
  logic [127:0] fwd, prev, t, mix;

  assign fwd  = fwd_step(rk_q, rcon(rnd_q));
  assign prev = inv_step(rk_q, rcon(rnd_q + 4'd1));

  aes_inv_round u_round (
    .state_i (blk_q),
    .rk_i    (prev),
    .t_o     (t),
    .mix_o   (mix)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ck_q, ck_d, crk_q, crk_d;
  logic         cvld_q, cvld_d, hit;
  assign hit = cvld_q && (cipher_key == ck_q);
`endif

  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    rk_d   = rk_q;
    rnd_d  = rnd_q;
    pt_d   = pt_q;
    vout_d = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
    ck_d   = ck_q;
    crk_d  = crk_q;
    cvld_d = cvld_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (valid_in) begin
`ifdef AES_DEC_KEY_CACHE_EN
          if (hit) begin
            rk_d  = crk_q;
            blk_d = cipher_text ^ crk_q;
            rnd_d = 4'd9;
            fsm_d = DEC;
          end else begin
            // Key is remembered now; it only becomes valid once rk10 is known.
            ck_d   = cipher_key;
            cvld_d = 1'b0;
            blk_d  = cipher_text;
            rk_d   = cipher_key;
            rnd_d  = 4'd1;
            fsm_d  = KEYEXP;
          end
`else
          blk_d = cipher_text;
          rk_d  = cipher_key;
          rnd_d = 4'd1;
          fsm_d = KEYEXP;
`endif
        end
      end
      KEYEXP: begin
        rk_d = fwd;
        if (rnd_q == 4'd10) begin
          blk_d = blk_q ^ fwd;
          rnd_d = 4'd9;
          fsm_d = DEC;
`ifdef AES_DEC_KEY_CACHE_EN
          crk_d  = fwd;
          cvld_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      DEC: begin
        if (rnd_q == 4'd0) begin
          pt_d   = t;
          vout_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          blk_d = mix;
          rk_d  = prev;
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q  <= IDLE;
      blk_q  <= '0;
      rk_q   <= '0;
      rnd_q  <= '0;
      pt_q   <= '0;
      vout_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rk_q   <= rk_d;
      rnd_q  <= rnd_d;
      pt_q   <= pt_d;
      vout_q <= vout_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ck_q   <= '0;
      crk_q  <= '0;
      cvld_q <= 1'b0;
    end else begin
      ck_q   <= ck_d;
      crk_q  <= crk_d;
      cvld_q <= cvld_d;
    end
  end
`endif

  assign ready_out  = (fsm_q == IDLE);
  assign plain_text = pt_q;
  assign valid_out  = vout_q;
endmodule
